mdu_ctrl: RTL and testbench

- Multiply/divide unit controller in the EX stage, driven by the decoder's is_multD/is_divD/hilo_wenD class of controls.
- Sequences a MUL_LAT-cycle multiply and a 32-iteration radix-2 restoring divider, and stalls the pipeline while busy.
- Produces HI/LO write data with hilo_wen, or a GPR result for MUL.
- Supports cancellation by exception flush.

---
 rtl/mdu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: MUL_LAT-cycle multiply, 32-step restoring divide, flush abort.
// Optional macro MDU_DIV_EARLY_OUT_EN: divides with |a| < |b| or b == 0 skip iteration.
module mdu_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hilo_wen_o,
  output logic        gpr_wen_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, quo_q, rem_q, dvs_q, hi_q, lo_q;
  logic        neg_q, neg_r, bzero_q;

  logic        op_valid, op_is_mul, accept, early;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, res_hi, res_lo;
  logic [32:0] shifted, diff;
  logic        mul_signed;
  logic signed [63:0] prod;

  assign op_valid  = (op_i <= OP_MUL);
  assign op_is_mul = (op_i == OP_MULT) | (op_i == OP_MULTU) | (op_i == OP_MUL);
  assign accept    = (state == S_IDLE) & start_i & op_valid & ~flush_i;

  assign a_neg = (op_i == OP_DIV) & src_a_i[31];
  assign b_neg = (op_i == OP_DIV) & src_b_i[31];
  assign mag_a = a_neg ? (~src_a_i + 32'd1) : src_a_i;
  assign mag_b = b_neg ? (~src_b_i + 32'd1) : src_b_i;

`ifdef MDU_DIV_EARLY_OUT_EN
  logic early_q;
  always_ff @(posedge clk) begin
    if (rst) early_q <= 1'b0;
    else if (accept) early_q <= (mag_a < mag_b) | (src_b_i == 32'd0);
  end
  assign early = early_q;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = op_is_mul ? ((MUL_LAT == 1) ? S_DONE : S_MUL) : S_DIV;
      S_MUL:  if (cnt == MUL_LAST) state_nxt = S_DONE;
      S_DIV:  if (early || cnt == DIV_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Flush outranks every transition; in IDLE it has already blocked accept.
    if (flush_i) state_nxt = S_IDLE;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_IDLE) ? 6'd0 : cnt + 6'd1;
      if (accept) begin
        op_q    <= op_i;
        a_q     <= src_a_i;
        b_q     <= src_b_i;
        quo_q   <= mag_a;
        rem_q   <= 32'd0;
        dvs_q   <= mag_b;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        bzero_q <= (src_b_i == 32'd0);
      end else if (state == S_DIV) begin
        if (early) begin
          rem_q <= quo_q;
          quo_q <= 32'd0;
        end else begin
          if (!diff[32]) rem_q <= diff[31:0];
          else rem_q <= shifted[31:0];
          quo_q <= {quo_q[30:0], ~diff[32]};
        end
      end
      if (done_o) begin
        hi_q <= hi_o;
        lo_q <= lo_o;
      end
    end
  end

  assign mul_signed = (op_q == OP_MULT) | (op_q == OP_MUL);
  assign prod = $signed({mul_signed & a_q[31], a_q}) * $signed({mul_signed & b_q[31], b_q});

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_MUL: res_lo = prod[31:0];
      default: begin
        if (bzero_q) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = neg_r ? (~rem_q + 32'd1) : rem_q;
          res_lo = neg_q ? (~quo_q + 32'd1) : quo_q;
        end
      end
    endcase
  end

  assign busy_o     = (state != S_IDLE);
  assign done_o     = (state == S_DONE) & ~flush_i;
  assign hilo_wen_o = done_o & (op_q != OP_MUL);
  assign gpr_wen_o  = done_o & (op_q == OP_MUL);
  assign stall_o    = (start_i & op_valid & (state == S_IDLE)) | (busy_o & (state != S_DONE));
  assign hi_o       = done_o ? res_hi : hi_q;
  assign lo_o       = done_o ? res_lo : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 2;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3, OP_MUL = 3'd4;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_o, busy_o, done_o, hilo_wen_o, gpr_wen_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mdl_hi, mdl_lo;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .hilo_wen_o(hilo_wen_o), .gpr_wen_o(gpr_wen_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] prev_hi);
    int sa, sb, q, r;
    longint sp;
    logic [63:0] up, res;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    res = {prev_hi, 32'd0};
    case (op)
      OP_MULT:  res = sp;
      OP_MULTU: res = up;
      OP_MUL:   res = {prev_hi, sp[31:0]};
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIVU) res = {a % b, a / b};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r, q};
        end
      end
      default: res = {prev_hi, 32'd0};
    endcase
    return res;
  endfunction

  function automatic int expected_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (op == OP_DIV && a[31]) ? -a : a;
    mb = (op == OP_DIV && b[31]) ? -b : b;
    if (op == OP_DIV || op == OP_DIVU) begin
`ifdef MDU_DIV_EARLY_OUT_EN
      if (b == 32'd0 || ma < mb) return 2;
`endif
      return 33;
    end
    return MUL_LAT;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
  endtask

  // Issue one op at the next negedge; flush_at > 0 raises flush in cycle T+flush_at.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    int lat, k;
    logic seen_done, stall_bad;
    logic [63:0] exp;
    exp_q.push_back(model(op, a, b, mdl_hi));
    lat = expected_lat(op, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; #1;
    chk("start_stall", stall_o, 1);
    chk("start_idle", busy_o, 0);
    k = 0; seen_done = 1'b0; stall_bad = 1'b0;
    while (!seen_done && k < 80) begin
      @(negedge clk);
      k++;
      start_i = 1'b0;
      src_a_i = $urandom; src_b_i = $urandom;
      flush_i = (k == flush_at);
      #1;
      if (flush_at > 0 && k == flush_at) break;
      if (done_o) seen_done = 1'b1;
      else if (!stall_o || !busy_o) stall_bad = 1'b1;
    end
    exp = exp_q.pop_front();
    if (flush_at > 0) begin
      chk("flush_no_done", {done_o, hilo_wen_o, gpr_wen_o}, 0);
      @(negedge clk);
      flush_i = 1'b0; #1;
      chk("flush_idle", busy_o, 0);
      chk("flush_hold", {hi_o, lo_o}, {mdl_hi, mdl_lo});
    end else begin
      chk("latency", k, lat);
      chk("stall_while_busy", stall_bad, 0);
      chk("done_stall", stall_o, 0);
      chk("result", {hi_o, lo_o}, exp);
      chk("wens", {hilo_wen_o, gpr_wen_o}, (op == OP_MUL) ? 2'b01 : 2'b10);
      mdl_hi = exp[63:32];
      mdl_lo = exp[31:0];
      @(negedge clk); #1;
      chk("after_done_idle", {busy_o, done_o}, 0);
      chk("held", {hi_o, lo_o}, {mdl_hi, mdl_lo});
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    do_reset();
    #1;
    chk("reset_outputs", {stall_o, busy_o, done_o, hilo_wen_o, gpr_wen_o, hi_o, lo_o}, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    chk("multu_val", {mdl_hi, mdl_lo}, {32'h0000_0001, 32'hFFFF_FFFE});
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_val", {mdl_hi, mdl_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, 0);
    chk("divz_val", {mdl_hi, mdl_lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op(OP_MUL, 32'd3, 32'hFFFF_FFFC, 0);
    chk("mul_val", {mdl_hi, mdl_lo}, {32'h1234_5678, 32'hFFFF_FFF4});
    run_op(OP_DIV, 32'd100, 32'd7, 10);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'd1000, 32'd3, expected_lat(OP_DIVU, 32'd1000, 32'd3));

    // start with flush, and an unused opcode, are both refused
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULT; #1;
    chk("flush_start_stall", stall_o, 1);
    @(negedge clk);
    op_i = 3'd5; flush_i = 1'b0; #1;
    chk("flush_start_refused", busy_o, 0);
    chk("bad_op_stall", stall_o, 0);
    @(negedge clk);
    start_i = 1'b0; #1;
    chk("bad_op_refused", busy_o, 0);

    // reset in the middle of a divide
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd77; src_b_i = 32'd5;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      chk("rst_mid_no_done", done_o, 0);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_outputs", {stall_o, busy_o, done_o, hilo_wen_o, gpr_wen_o, hi_o, lo_o}, 0);
    rst = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_val", {mdl_hi, mdl_lo}, {32'd0, 32'h8000_0000});

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      int fl;
      op = 3'($urandom_range(0, 4));
      a = rand_operand();
      b = rand_operand();
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, expected_lat(op, a, b)) : 0;
      run_op(op, a, b, fl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
